// File: rtl/apb_bridge_ctrl_if.sv
// rtl/apb_bridge_ctrl_if.sv - AHB-side request/response and APB-side bus signals of the bridge
interface apb_bridge_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4
);
    logic              valid;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic [NSLV-1:0]   slv_sel;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic [NSLV-1:0]   psel;
    logic              penable;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    // master: the bridge itself (AHB slave, APB master)
    modport master (
        input  valid, hwrite, haddr, hwdata, slv_sel, pready, prdata, pslverr,
        output hreadyout, hresp, hrdata, paddr, pwdata, pwrite, psel, penable
    );

    // slave: the surrounding AHB fabric and APB slaves
    modport slave (
        output valid, hwrite, haddr, hwdata, slv_sel, pready, prdata, pslverr,
        input  hreadyout, hresp, hrdata, paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/apb_bridge_ctrl.sv
// rtl/apb_bridge_ctrl.sv - AHB-to-APB bridge FSM with slave-select check, ACCESS timeout and two-cycle error response
module apb_bridge_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                hclk,
    input  logic                hresetn,
    apb_bridge_ctrl_if.master   bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WWAIT  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic [NSLV-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_ok;

    assign sel_ok = (bus.slv_sel != '0) &&
                    ((bus.slv_sel & (bus.slv_sel - NSLV'(1))) == '0);

    assign bus.paddr  = paddr_q;
    assign bus.pwdata = pwdata_q;
    assign bus.pwrite = pwrite_q;
    assign bus.hrdata = hrdata_q;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            sel_q    <= '0;
            hrdata_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            sel_q    <= sel_d;
            hrdata_q <= hrdata_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        sel_d         = sel_q;
        hrdata_d      = hrdata_q;
        cnt_d         = cnt_q;
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b0;
        bus.psel      = '0;
        bus.penable   = 1'b0;

        case (state_q)
            WWAIT: begin
                pwdata_d = bus.hwdata;
                state_d  = SETUP;
            end
            SETUP: begin
                bus.psel = sel_q;
                cnt_d    = '0;
                state_d  = ACCESS;
            end
            ACCESS: begin
                bus.psel    = sel_q;
                bus.penable = 1'b1;
                // pready is checked first so a completion on the limit cycle still succeeds
                if (bus.pready) begin
                    if (bus.pslverr) begin
                        state_d = ERR1;
                    end else begin
                        if (!pwrite_q) begin
                            hrdata_d = bus.prdata;
                        end
                        state_d = IDLE;
                    end
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d = ERR1;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR1: begin
                bus.hresp = 1'b1;
                state_d   = ERR2;
            end
            ERR2: begin
                bus.hresp     = 1'b1;
                bus.hreadyout = 1'b1;
                state_d       = IDLE;
            end
            // IDLE, and any unused encoding recovers through the same path
            default: begin
                bus.hreadyout = 1'b1;
                state_d       = IDLE;
                if (bus.valid) begin
                    paddr_d  = bus.haddr;
                    pwrite_d = bus.hwrite;
                    sel_d    = bus.slv_sel;
                    pwdata_d = '0;
                    if (!sel_ok) begin
                        state_d = ERR1;
                    end else if (bus.hwrite) begin
                        state_d = WWAIT;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
        endcase
    end
endmodule

// File: doc/apb_bridge_ctrl.md
APB_BRIDGE_CTRL -- requirements
Module: apb_bridge_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter NSLV, default 4, number of APB slaves (legal range 1..8).
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles; 0 disables the timeout.
REQ-005 SHALL have ports: hclk in 1, clock; hresetn in 1, reset, synchronous, active-low.
REQ-006 SHALL have AHB-side ports: valid in 1, transfer request; hwrite in 1, direction; haddr in ADDR_W; hwdata in DATA_W, valid one cycle after address; slv_sel in NSLV, decoded slave select; hreadyout out 1; hresp out 1, error; hrdata out DATA_W.
REQ-007 SHALL have APB-side ports: paddr out ADDR_W; pwdata out DATA_W; pwrite out 1; psel out NSLV; penable out 1; pready in 1; prdata in DATA_W; pslverr in 1 (pready, prdata and pslverr pre-muxed externally).

Function
REQ-008 SHALL implement FSM states IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
REQ-009 SHALL drive all outputs from state and registered data only, with no combinational input-to-output path.
REQ-010 SHALL, in IDLE, drive hreadyout=1 and hresp=0, and deassert psel and penable.
REQ-011 SHALL, in IDLE with valid=1, latch haddr, hwrite and slv_sel; next state is ERR1 if slv_sel is zero or not one-hot, else WWAIT if hwrite=1, else SETUP.
REQ-012 SHALL, in WWAIT, drive hreadyout=0, capture hwdata into the pwdata register, and go to SETUP.
REQ-013 SHALL, in SETUP, drive psel=latched slv_sel, penable=0, paddr/pwrite from the latches, pwdata from the register (0 for reads), and hreadyout=0; next state ACCESS; timeout counter cleared.
REQ-014 SHALL, in ACCESS, hold psel and all APB fields stable, drive penable=1 and hreadyout=0, and count cycles.
REQ-015 SHALL, in ACCESS with pready=1 and pslverr=0, capture prdata into hrdata on reads only and return to IDLE.
REQ-016 SHALL, in ACCESS with pready=1 and pslverr=1, go to ERR1 and leave hrdata unchanged.
REQ-017 SHALL, with TIMEOUT>0, go to ERR1 when ACCESS has lasted TIMEOUT cycles with pready=0; the counter is $clog2(TIMEOUT+1) bits and does not wrap.
REQ-018 SHALL take pready=1 on the same cycle as the timeout limit as a normal completion (pready wins).
REQ-019 SHALL, in ERR1, drive hresp=1, hreadyout=0, psel=0 and penable=0, then go to ERR2.
REQ-020 SHALL, in ERR2, drive hresp=1 and hreadyout=1, ignore valid, and go to IDLE.
REQ-021 SHALL complete a transfer in a minimum of 3 wait cycles for a write (WWAIT, SETUP, ACCESS) and 2 for a read, each extended by one cycle per pready=0 cycle.
REQ-022 SHALL update hrdata only on successful read completion; it holds its value otherwise.
REQ-023 SHALL treat an unreachable or encoded-illegal state as IDLE.

Reset
REQ-024 SHALL, on a hclk edge with hresetn=0, set state IDLE, paddr=0, pwdata=0, pwrite=0, psel=0, penable=0, hreadyout=1, hresp=0, hrdata=0, and clear the counter.
REQ-025 SHALL, on reset during SETUP or ACCESS, drop psel and penable at the same edge and abandon the transfer without any error response.

Verification
REQ-026 Write, slv_sel=4'b0010, haddr=0x100, hwdata=0xDEADBEEF, pready=1 -> WWAIT, SETUP, ACCESS with psel=0010, pwrite=1, pwdata=0xDEADBEEF; hreadyout low for 3 cycles, then high.
REQ-027 Read, slv_sel=4'b1000, pready low for 2 ACCESS cycles, prdata=0x12345678 -> penable high 3 cycles; hrdata=0x12345678 in IDLE.
REQ-028 Read with pslverr=1 at pready -> ERR1 (hresp=1, hreadyout=0), then ERR2 (hresp=1, hreadyout=1); hrdata unchanged.
REQ-029 TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then ERR1/ERR2; repeat with pready=1 on the 4th cycle -> normal completion.
REQ-030 slv_sel=0 and slv_sel=4'b0101 -> no psel activity; two-cycle error response.
REQ-031 hresetn=0 asserted in ACCESS -> next edge psel=0, penable=0, hreadyout=1; a following read completes normally.
